serial_adder: RTL and testbench

//   Bit-serial unsigned adder, LSB first, one operand bit pair per clock.

---
 rtl/serial_adder.sv | 90 +++++++++
 tb/tb_serial_adder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial unsigned adder, LSB first, {carry_out, sum} result
// One operand bit pair per clock; result and done appear WIDTH cycles after start is accepted.
module serial_adder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   s
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] racc;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             sbit;
   logic             cout;
   logic [WIDTH:0]   acc_ext;
   logic [WIDTH-1:0] racc_next;

   // Sum bit enters at the accumulator MSB so bit 0 ends up at the LSB after WIDTH shifts.
   always_comb begin
      sbit      = ra[0] ^ rb[0] ^ carry;
      cout      = (ra[0] & rb[0]) | (carry & (ra[0] ^ rb[0]));
      acc_ext   = {sbit, racc};
      racc_next = acc_ext[WIDTH:1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ra    <= '0;
         rb    <= '0;
         racc  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         s     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  ra    <= a;
                  rb    <= b;
                  racc  <= '0;
                  carry <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               ra    <= ra >> 1;
               rb    <= rb >> 1;
               racc  <= racc_next;
               carry <= cout;
               cnt   <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  s     <= {cout, racc_next};
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=4)
module tb_serial_adder;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       busy;
   logic       done;
   logic [4:0] s;

   int n_cmp  = 0;
   int n_fail = 0;

   serial_adder #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .s     (s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [4:0] s;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge with the DUT idle again.
   task automatic do_op(input logic [3:0] ta, input logic [3:0] tb, input bit inject,
                        output int got, output int lat, output int bc, output int dc,
                        output int s_end);
      got = -1;
      lat = -1;
      bc  = 0;
      dc  = 0;
      a = ta;
      b = tb;
      start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 0) begin
            start = 1'b0;
            a = 4'($urandom_range(15, 0));
            b = 4'($urandom_range(15, 0));
         end
         if (inject && k == 1) begin
            start = 1'b1;
            a = 4'd1;
            b = 4'd1;
         end
         if (inject && k == 2) start = 1'b0;
         if (busy) bc++;
         if (done) begin
            dc++;
            if (lat < 0) lat = k;
            got = int'(s);
         end
      end
      s_end = int'(s);
   endtask

   // start held high; a new operand pair is presented as each result appears.
   task automatic run_stream(input bit round_trip);
      int idx  = 0;
      int got  = 0;
      int last = -1;
      int cyc  = 0;
      logic [3:0] ta, tb;
      ta = 4'(idx >> 4);
      tb = 4'(idx);
      a  = round_trip ? 4'(ta - tb) : ta;
      b  = tb;
      start = 1'b1;
      while (got < 256 && cyc < 256 * 6 + 40) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            ta = 4'(idx >> 4);
            tb = 4'(idx);
            if (round_trip)
               chk($sformatf("round_trip a=%0d b=%0d", ta, tb), int'(s[3:0]), int'(ta));
            else
               chk($sformatf("exhaustive %0d+%0d", ta, tb), int'(s), int'(ta) + int'(tb));
            if (last >= 0 && (cyc - last) != 6)
               chk("stream_spacing", cyc - last, 6);
            last = cyc;
            got++;
            idx++;
            if (idx < 256) begin
               ta = 4'(idx >> 4);
               tb = 4'(idx);
               a  = round_trip ? 4'(ta - tb) : ta;
               b  = tb;
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      chk(round_trip ? "round_trip_count" : "exhaustive_count", got, 256);
      repeat (4) @(negedge clk);
   endtask

   vec_t tbl[6];
   int got, lat, bc, dc, s_end, nd;
   logic [3:0] ra_v, rb_v;

   initial begin
      tbl[0] = '{4'b0011, 4'b0101, 5'b01000};
      tbl[1] = '{4'd15,   4'd15,   5'b11110};
      tbl[2] = '{4'd0,    4'd0,    5'b00000};
      tbl[3] = '{4'd15,   4'd1,    5'b10000};
      tbl[4] = '{4'd10,   4'd4,    5'd14};
      tbl[5] = '{4'd7,    4'd9,    5'd16};

      rst_n = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_s", int'(s), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         do_op(tbl[i].a, tbl[i].b, 1'b0, got, lat, bc, dc, s_end);
         chk($sformatf("vec%0d_s", i), got, int'(tbl[i].s));
         chk($sformatf("vec%0d_latency", i), lat, 4);
         chk($sformatf("vec%0d_busy_cycles", i), bc, 5);
         chk($sformatf("vec%0d_done_pulses", i), dc, 1);
         chk($sformatf("vec%0d_s_held", i), s_end, int'(tbl[i].s));
      end

      // start during SHIFT is ignored
      do_op(4'b0011, 4'b0101, 1'b1, got, lat, bc, dc, s_end);
      chk("ignore_start_s", got, 8);
      chk("ignore_start_done_pulses", dc, 1);
      chk("ignore_start_busy_cycles", bc, 5);
      chk("ignore_start_s_held", s_end, 8);

      // asynchronous reset in the middle of SHIFT
      a = 4'd9;
      b = 4'd6;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_done", int'(done), 0);
      chk("async_rst_s", int'(s), 0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      repeat (10) begin
         @(negedge clk);
         if (done || busy) nd++;
      end
      chk("no_activity_after_reset", nd, 0);
      do_op(4'd12, 4'd7, 1'b0, got, lat, bc, dc, s_end);
      chk("after_reset_s", got, 19);
      chk("after_reset_latency", lat, 4);

      // random operations with random idle gaps against plain arithmetic
      for (int i = 0; i < 30; i++) begin
         ra_v = 4'($urandom_range(15, 0));
         rb_v = 4'($urandom_range(15, 0));
         repeat ($urandom_range(3, 0)) @(negedge clk);
         do_op(ra_v, rb_v, 1'b0, got, lat, bc, dc, s_end);
         chk($sformatf("random %0d+%0d", ra_v, rb_v), got, int'(ra_v) + int'(rb_v));
         chk("random_latency", lat, 4);
      end

      run_stream(1'b0);
      run_stream(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
